// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one fully pipelined, fixed-latency ALU between
// NUM_REQ requesters.
//   - Round-robin grant (combinational req_ready); the search starts just
//     after the last granted requester.
//   - The granted operation is registered onto the alu_* issue port.
//   - A tag pipeline (valid + owner) follows each operation through the ALU.
//     Its last stage lines up with the cycle in which alu_result is valid.
//   - The result/flags come back as a one-cycle one-hot rsp_valid pulse.
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   arb_en             0 = no new grants; in-flight operations still drain
//   req_valid/ready    per-requester handshake; req_ready is one-hot
//   req_opcode/a/b/signed  per-requester operation, slice i = requester i
//   alu_valid/opcode/a/b/signed  registered issue port to the ALU
//   alu_result/flags   ALU output, ALU_LATENCY cycles after alu_valid;
//                      flags are {zero, carry, overflow, negative}
//   rsp_valid          one-hot response pulse; rsp_result/rsp_flags shared
//   busy               registered; high while any operation is in flight
//
// Optional build macro ALU_ARB_STATS_EN adds:
//   stat_clr           synchronous clear of all grant counters
//   stat_grants        one 16-bit saturating grant counter per requester
module alu_req_arbiter #(
  parameter int WIDTH       = 32,
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 2,
  parameter int OPCODE_W    = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               arb_en,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][OPCODE_W-1:0]   req_opcode,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]      req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]      req_b,
  input  logic [NUM_REQ-1:0]                 req_signed,
  output logic                               alu_valid,
  output logic [OPCODE_W-1:0]                alu_opcode,
  output logic [WIDTH-1:0]                   alu_a,
  output logic [WIDTH-1:0]                   alu_b,
  output logic                               alu_signed,
  input  logic [WIDTH-1:0]                   alu_result,
  input  logic [3:0]                         alu_flags,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [WIDTH-1:0]                   rsp_result,
  output logic [3:0]                         rsp_flags,
  output logic                               busy
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                               stat_clr,
  output logic [NUM_REQ-1:0][15:0]           stat_grants
`endif
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = ALU_LATENCY;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                sgn;
  } alu_req_t;

  logic [IDX_W-1:0]             ptr;
  logic [IDX_W-1:0]             gidx;
  logic                         hs;
  alu_req_t                     sel_req;
  alu_req_t                     issue_q;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][IDX_W-1:0]   own_pipe;
  logic [NUM_REQ-1:0]           rsp_nxt;

  // Round-robin search from ptr+1, wrapping. req_ready is forced low while
  // reset is asserted so every output reads 0 during reset.
  always_comb begin
    req_ready = '0;
    gidx      = ptr;
    hs        = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!hs && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        hs   = 1'b1;
        gidx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
    if (!(arb_en && rst_n)) hs = 1'b0;
    if (hs) req_ready[gidx] = 1'b1;
  end

  assign sel_req = {req_opcode[gidx], req_a[gidx], req_b[gidx], req_signed[gidx]};

  assign alu_opcode = issue_q.opcode;
  assign alu_a      = issue_q.a;
  assign alu_b      = issue_q.b;
  assign alu_signed = issue_q.sgn;

  // Owner of the operation whose result is on alu_result this cycle.
  always_comb begin
    rsp_nxt = '0;
    if (vld_pipe[STAGES]) rsp_nxt[own_pipe[STAGES]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= IDX_W'(NUM_REQ - 1);
      alu_valid  <= 1'b0;
      issue_q    <= '0;
      vld_pipe   <= '0;
      own_pipe   <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      busy       <= 1'b0;
    end else begin
      alu_valid <= hs;
      if (hs) begin
        ptr     <= gidx;
        issue_q <= sel_req;
      end
      vld_pipe[0] <= hs;
      own_pipe[0] <= gidx;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        own_pipe[k] <= own_pipe[k-1];
      end
      rsp_valid <= rsp_nxt;
      if (vld_pipe[STAGES]) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
      end
      // Next-cycle view: a new issue, any stage still shifting, or an entry
      // leaving the last stage (which becomes next cycle's rsp_valid).
      busy <= hs | (|vld_pipe);
    end
  end

`ifdef ALU_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        stat_grants[i] <= '0;
      else if (stat_clr)
        stat_grants[i] <= '0;
      else if (req_ready[i] && stat_grants[i] != 16'hFFFF)
        stat_grants[i] <= stat_grants[i] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a stand-in ALU with ALU_LATENCY=2, directed
// scenarios and a random phase, all checked against a cycle-indexed
// reference model (round-robin pointer, expected-response queue).
module tb_alu_req_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int L  = 2;
  localparam int OW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, arb_en;
  logic [N-1:0]           req_valid, req_ready, req_signed;
  logic [N-1:0][OW-1:0]   req_opcode;
  logic [N-1:0][W-1:0]    req_a, req_b;
  logic                   alu_valid, alu_signed;
  logic [OW-1:0]          alu_opcode;
  logic [W-1:0]           alu_a, alu_b, alu_result;
  logic [3:0]             alu_flags;
  logic [N-1:0]           rsp_valid;
  logic [W-1:0]           rsp_result;
  logic [3:0]             rsp_flags;
  logic                   busy;
`ifdef ALU_ARB_STATS_EN
  logic                   stat_clr, clr_n;
  logic [N-1:0][15:0]     stat_grants;
`endif

  alu_req_arbiter #(.WIDTH(W), .NUM_REQ(N), .ALU_LATENCY(L), .OPCODE_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
    .alu_valid(alu_valid), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_signed(alu_signed), .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_grants(stat_grants)
`endif
  );

  // Reference ALU: returns {zero, carry, overflow, negative, result}.
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic s);
    logic [32:0] t;
    logic        v;
    t = '0;
    v = 1'b0;
    case (op[1:0])
      2'd0: begin t = {1'b0, a} + {1'b0, b}; v = s && (a[31] == b[31]) && (t[31] != a[31]); end
      2'd1: begin t = {1'b0, a} - {1'b0, b}; v = s && (a[31] != b[31]) && (t[31] != a[31]); end
      2'd2: t = {1'b0, a & b};
      default: t = {1'b0, a ^ b};
    endcase
    return {t[31:0] == 32'd0, t[32], v, t[31], t[31:0]};
  endfunction

  // Stand-in ALU, L cycles from alu_valid; garbage when nothing is valid.
  logic [L-1:0]        pv = '0;
  logic [L-1:0][35:0]  pd;
  always @(posedge clk) begin
    pv <= {pv[L-2:0], alu_valid};
    pd <= {pd[L-2:0], alu_fn(alu_opcode, alu_a, alu_b, alu_signed)};
  end
  assign alu_result = pv[L-1] ? pd[L-1][31:0]  : 32'hDEADBEEF;
  assign alu_flags  = pv[L-1] ? pd[L-1][35:32] : 4'hF;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state
  typedef struct {int cyc; int own; logic [35:0] d;} exp_t;
  exp_t                 eq[$];
  int                   hs_q[$];
  int                   cyc = 0;
  int                   mptr, last_hs;
  logic [35:0]          last_d;
  logic [OW+2*W:0]      iss;
  logic [N-1:0][OW-1:0] op_n;
  logic [N-1:0][W-1:0]  a_n, b_n;
  logic [N-1:0]         s_n;

  task automatic mreset();
    mptr    = N - 1;
    eq.delete();
    hs_q.delete();
    last_hs = -100;
    last_d  = '0;
  endtask

  // One cycle: check registered outputs, drive new inputs at the negedge,
  // then check the combinational grant and update the model.
  task automatic step(input logic [N-1:0] v, input logic en, input bit rnd);
    logic [N-1:0] g, erv;
    int           j;
    bit           eb;
    @(negedge clk);
    cyc++;
    erv = '0;
    if (eq.size() > 0 && eq[0].cyc == cyc) begin
      erv[eq[0].own] = 1'b1;
      last_d = eq[0].d;
      void'(eq.pop_front());
    end
    chk("rsp_valid", rsp_valid, erv);
    chk("rsp_result", rsp_result, last_d[31:0]);
    chk("rsp_flags", rsp_flags, last_d[35:32]);
    eb = 1'b0;
    foreach (hs_q[k]) if (cyc - hs_q[k] >= 1 && cyc - hs_q[k] <= L + 2) eb = 1'b1;
    while (hs_q.size() > 0 && cyc - hs_q[0] > L + 2) void'(hs_q.pop_front());
    chk("busy", busy, eb);
    chk("alu_valid", alu_valid, last_hs == cyc - 1);
    if (last_hs == cyc - 1) chk("alu_issue", {alu_opcode, alu_a, alu_b, alu_signed}, iss);
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        op_n[i] = OW'($urandom_range(0, 15));
        a_n[i]  = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
        b_n[i]  = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
        s_n[i]  = 1'($urandom_range(0, 1));
      end
    end
    req_opcode = op_n;
    req_a      = a_n;
    req_b      = b_n;
    req_signed = s_n;
    req_valid  = v;
    arb_en     = en;
`ifdef ALU_ARB_STATS_EN
    stat_clr   = clr_n;
`endif
    #1;
    g = '0;
    j = 0;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        if (v[(mptr + k) % N]) begin
          j = (mptr + k) % N;
          g[j] = 1'b1;
          break;
        end
      end
    end
    chk("req_ready", req_ready, g);
    if (g != 0) begin
      mptr = j;
      eq.push_back('{cyc + L + 2, j, alu_fn(op_n[j], a_n[j], b_n[j], s_n[j])});
      hs_q.push_back(cyc);
      last_hs = cyc;
      iss = {op_n[j], a_n[j], b_n[j], s_n[j]};
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, req_ready, '0);
    chk({tag, "_alu"}, {alu_valid, alu_opcode, alu_a, alu_b, alu_signed}, '0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_result, rsp_flags}, '0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    arb_en = 1'b1;
    op_n = '0; a_n = '0; b_n = '0; s_n = '0;
    req_opcode = '0; req_a = '0; req_b = '0; req_signed = '0;
    req_valid = '1;
`ifdef ALU_ARB_STATS_EN
    clr_n = 1'b0;
    stat_clr = 1'b0;
`endif
    #12;
    check_all_zero("reset");
`ifdef ALU_ARB_STATS_EN
    chk("stat_reset", stat_grants, '0);
`endif
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mreset();

    // Rotation with every requester asking
    for (int i = 0; i < 5; i++) begin
      logic [N-1:0] e;
      step('1, 1'b1, 1'b1);
      e = '0;
      e[i % N] = 1'b1;
      chk("rr_seq", req_ready, e);
    end
    repeat (8) step('0, 1'b1, 1'b0);

    // Requester 2 alone: signed overflow on ADD
    op_n[2] = 4'd0; a_n[2] = 32'h7FFFFFFF; b_n[2] = 32'h1; s_n[2] = 1'b1;
    step(4'b0100, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("ovf_issue", alu_valid, 1'b1);
    repeat (3) step('0, 1'b1, 1'b0);
    chk("ovf_rsp_valid", rsp_valid, 4'b0100);
    chk("ovf_result", rsp_result, 32'h80000000);
    chk("ovf_flags", rsp_flags, 4'b0011);
    repeat (4) step('0, 1'b1, 1'b0);

    // Back-to-back grants to 0, 1, 3
    op_n[0] = 4'd1; a_n[0] = 32'd5;         b_n[0] = 32'd7;         s_n[0] = 1'b0;
    op_n[1] = 4'd2; a_n[1] = 32'hF0F0F0F0;  b_n[1] = 32'hFF00FF00;  s_n[1] = 1'b0;
    op_n[3] = 4'd3; a_n[3] = 32'h12345678;  b_n[3] = 32'h12345678;  s_n[3] = 1'b0;
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    repeat (2) step('0, 1'b1, 1'b0);
    chk("b2b_rsp0", {rsp_valid, rsp_result}, {4'b0001, 32'hFFFFFFFE});
    step('0, 1'b1, 1'b0);
    chk("b2b_rsp1", {rsp_valid, rsp_result}, {4'b0010, 32'hF000F000});
    step('0, 1'b1, 1'b0);
    chk("b2b_rsp3", {rsp_valid, rsp_result, rsp_flags[3]}, {4'b1000, 32'h0, 1'b1});
    chk("b2b_busy_last", busy, 1'b1);
    step('0, 1'b1, 1'b0);
    chk("b2b_busy_fall", busy, 1'b0);

    // Two issues, then arb_en low with everyone requesting
    step(4'b0001, 1'b1, 1'b1);
    step(4'b0100, 1'b1, 1'b1);
    repeat (6) begin
      step('1, 1'b0, 1'b1);
      chk("en_off_ready", req_ready, '0);
    end
    chk("en_off_busy", busy, 1'b0);
    step('1, 1'b1, 1'b1);
    chk("en_resume", req_ready, 4'b1000);
    repeat (6) step('0, 1'b1, 1'b0);

    // Reset while two operations are in flight
    step(4'b0010, 1'b1, 1'b1);
    step(4'b0001, 1'b1, 1'b1);
    step('0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    mreset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) step('0, 1'b1, 1'b0);

    // Random traffic
    repeat (400) step(N'($urandom), 1'($urandom_range(0, 7) != 0), 1'b1);
    repeat (8) step('0, 1'b1, 1'b0);

`ifdef ALU_ARB_STATS_EN
    repeat (70000) step(4'b0010, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("stat_sat", stat_grants[1], 16'hFFFF);
    clr_n = 1'b1;
    step(4'b0010, 1'b1, 1'b0);
    clr_n = 1'b0;
    step('0, 1'b1, 1'b0);
    chk("stat_clr", stat_grants[1], 16'h0000);
    repeat (6) step('0, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
